// File: rtl/cp0_if.sv
// -----------------------------------------------------------------------------
// cp0_if -- bundle between the pipeline (master) and the CP0 register file
// (slave).
//
// Master drives:
//   cp0write/waddr/wdata        MTC0 write strobe, target register, data
//   raddr                       MFC0 source register
//   int_i                       hardware interrupt lines HW[5:0], level-sensitive
//   exc_valid/exc_code/exc_pc/exc_bd/exc_badvaddr
//                               exception commit and its attributes
//   eret                        ERET commit
// Slave drives:
//   rdata                       MFC0 read data (combinational)
//   flush/new_pc                pipeline redirect request and target
//   int_req                     pending enabled interrupt
//   status_o/cause_o/epc_o      current register values
// -----------------------------------------------------------------------------
interface cp0_if;
    logic        cp0write;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr;
    logic [31:0] rdata;
    logic [5:0]  int_i;
    logic        exc_valid;
    logic [4:0]  exc_code;
    logic [31:0] exc_pc;
    logic        exc_bd;
    logic [31:0] exc_badvaddr;
    logic        eret;
    logic        flush;
    logic [31:0] new_pc;
    logic        int_req;
    logic [31:0] status_o;
    logic [31:0] cause_o;
    logic [31:0] epc_o;

    modport master (
        output cp0write, waddr, wdata, raddr, int_i,
        output exc_valid, exc_code, exc_pc, exc_bd, exc_badvaddr, eret,
        input  rdata, flush, new_pc, int_req, status_o, cause_o, epc_o
    );

    modport slave (
        input  cp0write, waddr, wdata, raddr, int_i,
        input  exc_valid, exc_code, exc_pc, exc_bd, exc_badvaddr, eret,
        output rdata, flush, new_pc, int_req, status_o, cause_o, epc_o
    );
endinterface

// File: rtl/cp0_regs.sv
// -----------------------------------------------------------------------------
// cp0_regs -- MIPS-style coprocessor-0 register file: BadVAddr, Count,
// Compare, Status, Cause and EPC, with exception entry, ERET return, the
// Count/Compare timer interrupt and the interrupt-pending request.
//
// Ports:
//   clk     rising-edge clock
//   resetn  asynchronous active-low reset
//   bus     cp0_if.slave: MTC0/MFC0 access, interrupt lines, exception and
//           ERET commit inputs; redirect, interrupt request and register
//           value outputs (see cp0_if.sv)
//
// Parameters:
//   STATUS_RESET  Status value loaded on reset (BEV set)
//   EXC_VECTOR    redirect target on exception entry
// -----------------------------------------------------------------------------
module cp0_regs #(
    parameter logic [31:0] STATUS_RESET = 32'h0040_0000,
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380
) (
    input logic  clk,
    input logic  resetn,
    cp0_if.slave bus
);

    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;

    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;

    // Status: only the writable fields are stored; BEV is a constant 1.
    logic [7:0]  status_im;
    logic        status_exl;
    logic        status_ie;

    // Cause: IP[15:10] mirror the interrupt lines, IP[9:8] are software bits.
    logic        cause_bd;
    logic        cause_ti;
    logic [7:0]  cause_ip;
    logic [4:0]  cause_exc;

    logic [31:0] epc;
    logic [31:0] badvaddr;
    logic [31:0] count;
    logic [31:0] compare;
    // Count advances on every other clock; tick marks the advancing cycle.
    logic        tick;

    logic [31:0] count_inc;
    logic        wr_count;
    logic        wr_compare;
    logic        wr_status;
    logic        wr_cause;
    logic        wr_epc;
    logic [31:0] status_val;
    logic [31:0] cause_val;

    function automatic logic [31:0] pack_status(
        input logic [7:0] im,
        input logic       exl,
        input logic       ie
    );
        return {9'b0, 1'b1, 6'b0, im, 6'b0, exl, ie};
    endfunction

    function automatic logic [31:0] pack_cause(
        input logic       bd,
        input logic       ti,
        input logic [7:0] ip,
        input logic [4:0] exc
    );
        return {bd, ti, 14'b0, ip, 1'b0, exc, 2'b0};
    endfunction

    assign count_inc  = count + 32'd1;
    assign wr_count   = bus.cp0write && (bus.waddr == REG_COUNT);
    assign wr_compare = bus.cp0write && (bus.waddr == REG_COMPARE);
    assign wr_status  = bus.cp0write && (bus.waddr == REG_STATUS);
    assign wr_cause   = bus.cp0write && (bus.waddr == REG_CAUSE);
    assign wr_epc     = bus.cp0write && (bus.waddr == REG_EPC);

    assign status_val = pack_status(status_im, status_exl, status_ie);
    assign cause_val  = pack_cause(cause_bd, cause_ti, cause_ip, cause_exc);

    // Updates are written lowest priority first (MTC0, then ERET, then
    // exception) so that the later nonblocking assignment owns any field
    // two sources try to write in the same cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            status_im  <= STATUS_RESET[15:8];
            status_exl <= STATUS_RESET[1];
            status_ie  <= STATUS_RESET[0];
            cause_bd   <= 1'b0;
            cause_ti   <= 1'b0;
            cause_ip   <= 8'b0;
            cause_exc  <= 5'b0;
            epc        <= 32'b0;
            badvaddr   <= 32'b0;
            count      <= 32'b0;
            compare    <= 32'b0;
            tick       <= 1'b0;
        end else begin
            // HW5 is shared with the timer interrupt, sampled from the
            // current TI so it follows TI by one cycle.
            cause_ip[7:2] <= {bus.int_i[5] | cause_ti, bus.int_i[4:0]};

            if (wr_count) begin
                count <= bus.wdata;
                tick  <= 1'b0;
            end else begin
                tick <= ~tick;
                if (tick) begin
                    count <= count_inc;
                    if (count_inc == compare) begin
                        cause_ti <= 1'b1;
                    end
                end
            end

            // Acknowledging the timer by rewriting Compare overrides a
            // coincident match.
            if (wr_compare) begin
                compare  <= bus.wdata;
                cause_ti <= 1'b0;
            end

            if (wr_status) begin
                status_im  <= bus.wdata[15:8];
                status_exl <= bus.wdata[1];
                status_ie  <= bus.wdata[0];
            end

            if (wr_cause) begin
                cause_ip[1:0] <= bus.wdata[9:8];
            end

            if (wr_epc) begin
                epc <= bus.wdata;
            end

            if (bus.eret) begin
                status_exl <= 1'b0;
            end

            if (bus.exc_valid) begin
                // A nested exception keeps the original return point.
                if (!status_exl) begin
                    epc      <= bus.exc_bd ? (bus.exc_pc - 32'd4) : bus.exc_pc;
                    cause_bd <= bus.exc_bd;
                end
                status_exl <= 1'b1;
                cause_exc  <= bus.exc_code;
                if ((bus.exc_code == EXC_ADEL) || (bus.exc_code == EXC_ADES)) begin
                    badvaddr <= bus.exc_badvaddr;
                end
            end
        end
    end

    always_comb begin
        bus.rdata = 32'b0;
        case (bus.raddr)
            REG_BADVADDR: bus.rdata = badvaddr;
            REG_COUNT:    bus.rdata = count;
            REG_COMPARE:  bus.rdata = compare;
            REG_STATUS:   bus.rdata = status_val;
            REG_CAUSE:    bus.rdata = cause_val;
            REG_EPC:      bus.rdata = epc;
            default:      bus.rdata = 32'b0;
        endcase
    end

    assign bus.flush    = bus.exc_valid | bus.eret;
    assign bus.new_pc   = bus.exc_valid ? EXC_VECTOR : epc;
    assign bus.int_req  = status_ie & ~status_exl & (|(cause_ip & status_im));
    assign bus.status_o = status_val;
    assign bus.cause_o  = cause_val;
    assign bus.epc_o    = epc;

endmodule
